// File: rtl/bus_arbiter_if.sv
// Requester, response and memory-bus signal bundle for bus_arbiter.
// The master modport is the arbiter's view; slave is the view of the requesters and the bus.
interface bus_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 3
);
   localparam int BE_W = DATA_W / 8;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        req_we;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ*BE_W-1:0]   req_be;
   logic [NUM_REQ*LEN_W-1:0]  req_len;
   logic [NUM_REQ-1:0]        resp_valid;
   logic [DATA_W-1:0]         resp_data;
   logic                      resp_last;
   logic                      bus_valid;
   logic                      bus_ready;
   logic [ADDR_W-1:0]         bus_addr;
   logic                      bus_we;
   logic [DATA_W-1:0]         bus_wdata;
   logic [BE_W-1:0]           bus_be;
   logic [LEN_W-1:0]          bus_len;
   logic                      bus_rvalid;
   logic [DATA_W-1:0]         bus_rdata;
   logic                      busy;

   modport master (
      input  req_valid, req_addr, req_we, req_wdata, req_be, req_len,
      input  bus_ready, bus_rvalid, bus_rdata,
      output req_ready, resp_valid, resp_data, resp_last,
      output bus_valid, bus_addr, bus_we, bus_wdata, bus_be, bus_len, busy
   );

   modport slave (
      output req_valid, req_addr, req_we, req_wdata, req_be, req_len,
      output bus_ready, bus_rvalid, bus_rdata,
      input  req_ready, resp_valid, resp_data, resp_last,
      input  bus_valid, bus_addr, bus_we, bus_wdata, bus_be, bus_len, busy
   );
endinterface

// File: rtl/bus_arbiter.sv
// Single-outstanding arbiter for the core-to-memory bus: arbitrate, address phase, data beats.
// Define BUS_ARB_RR_EN for round-robin arbitration; otherwise index 0 has fixed highest priority.
//
// state  | meaning
// S_IDLE | no transaction; pick a winner and latch its request
// S_ADDR | bus_valid held with latched fields until bus_ready
// S_DATA | forward response beats to the granted requester until the last one
module bus_arbiter #(
   parameter int                 NUM_REQ    = 3,
   parameter int                 ADDR_W     = 32,
   parameter int                 DATA_W     = 32,
   parameter int                 LEN_W      = 3,
   parameter logic [NUM_REQ-1:0] FLUSH_MASK = 3'b110
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   bus_arbiter_if.master bus
);
   localparam int BE_W  = DATA_W / 8;
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

   state_t              state;
   logic [IDX_W-1:0]    grant;
   logic [IDX_W-1:0]    winner;
   logic [IDX_W-1:0]    search_start;
   logic                win_found;
   logic [ADDR_W-1:0]   addr_q;
   logic                we_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [BE_W-1:0]     be_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    cnt_q;
   logic                drop_q;
   logic                bus_valid_q;
   logic                busy_q;
   logic                flush_hit;
   logic                drop_now;
   logic                beat;
   logic                proto_err;

`ifdef BUS_ARB_RR_EN
   // rr_ptr holds the index just after the last winner, so the first search after reset starts at 0
   logic [IDX_W-1:0] rr_ptr;
   assign search_start = rr_ptr;

   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= '0;
      else if (state == S_IDLE && win_found)
         rr_ptr <= (winner == IDX_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
   end
`else
   assign search_start = '0;
`endif

   always_comb begin
      logic [IDX_W-1:0] idx;
      winner    = '0;
      win_found = 1'b0;
      idx       = search_start;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!win_found && bus.req_valid[idx]) begin
            winner    = idx;
            win_found = 1'b1;
         end
         idx = (idx == IDX_W'(NUM_REQ-1)) ? '0 : idx + 1'b1;
      end
   end

   // A flush in the same cycle as a beat must already suppress that beat
   assign flush_hit = flush & FLUSH_MASK[grant];
   assign drop_now  = drop_q | flush_hit;
   assign beat      = (state == S_DATA) & bus.bus_rvalid;
   assign proto_err = bus.bus_rvalid & (state != S_DATA);

   always_comb begin
      bus.req_ready = '0;
      if (state == S_IDLE && win_found && !rst)
         bus.req_ready[winner] = 1'b1;
   end

   always_comb begin
      bus.resp_valid = '0;
      if (beat && !drop_now)
         bus.resp_valid[grant] = 1'b1;
   end

   assign bus.resp_data = (state == S_DATA) ? bus.bus_rdata : '0;
   assign bus.resp_last = beat & ~drop_now & (cnt_q == '0);
   assign bus.bus_valid = bus_valid_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_we    = we_q;
   assign bus.bus_wdata = wdata_q;
   assign bus.bus_be    = be_q;
   assign bus.bus_len   = len_q;
   assign bus.busy      = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         grant       <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         be_q        <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         drop_q      <= 1'b0;
         bus_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (win_found) begin
                  grant       <= winner;
                  addr_q      <= bus.req_addr[winner*ADDR_W +: ADDR_W];
                  we_q        <= bus.req_we[winner];
                  wdata_q     <= bus.req_wdata[winner*DATA_W +: DATA_W];
                  be_q        <= bus.req_be[winner*BE_W +: BE_W];
                  len_q       <= bus.req_we[winner] ? '0 : bus.req_len[winner*LEN_W +: LEN_W];
                  bus_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state       <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (flush_hit)
                  drop_q <= 1'b1;
               if (bus.bus_ready) begin
                  cnt_q       <= len_q;
                  bus_valid_q <= 1'b0;
                  state       <= S_DATA;
               end
            end
            S_DATA: begin
               if (flush_hit)
                  drop_q <= 1'b1;
               if (bus.bus_rvalid) begin
                  if (cnt_q == '0) begin
                     drop_q <= 1'b0;
                     busy_q <= 1'b0;
                     state  <= S_IDLE;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Stray response beats are dropped in hardware; flag them loudly in simulation
   always_ff @(posedge clk) begin
      if (!rst)
         assert (!proto_err) else $warning("bus_arbiter: bus_rvalid outside data phase ignored");
   end
endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter against a transaction-level model.
module tb_bus_arbiter;
   localparam int         NUM_REQ    = 3;
   localparam logic [2:0] FLUSH_MASK = 3'b110;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   bus_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(32), .DATA_W(32), .LEN_W(3)) bif ();

   bus_arbiter dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] a_addr[3];
   logic [31:0] a_wdata[3];
   logic [3:0]  a_be[3];
   logic [2:0]  a_len[3];
   logic        a_we[3];

   logic        chk_en = 1'b0;
   logic [2:0]  e_req_ready, e_resp_valid;
   logic [31:0] e_resp_data;
   logic        e_resp_last, e_bus_valid, e_busy;
   logic [31:0] e_addr, e_wdata;
   logic        e_we;
   logic [3:0]  e_be;
   logic [2:0]  e_len;

   int          mon_bus_valid, mon_busy, mon_last, mon_rbeats, mon_grant;
   int          mon_resp[3];
   logic [2:0]  mon_bus_len;
   logic [3:0]  mon_bus_be;
   int          model_start = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [2:0] v, input int start);
      for (int k = 0; k < NUM_REQ; k++) begin
         int i;
         i = (start + k) % NUM_REQ;
         if (((v >> i) & 3'b001) != 3'b000) return i;
      end
      return 0;
   endfunction

   always @(negedge clk) begin
      if (bif.bus_valid) begin
         mon_bus_valid++;
         mon_bus_len = bif.bus_len;
         mon_bus_be  = bif.bus_be;
      end
      if (bif.busy) mon_busy++;
      if (bif.resp_last) mon_last++;
      if (bif.busy && bif.bus_rvalid) mon_rbeats++;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (((bif.resp_valid >> i) & 3'b001) != 3'b000) mon_resp[i]++;
         if (((bif.req_ready >> i) & 3'b001) != 3'b000) mon_grant = i;
      end
      if (chk_en) begin
         check("req_ready", bif.req_ready, e_req_ready);
         check("resp_valid", bif.resp_valid, e_resp_valid);
         check("resp_data", bif.resp_data, e_resp_data);
         check("resp_last", bif.resp_last, e_resp_last);
         check("bus_valid", bif.bus_valid, e_bus_valid);
         check("busy", bif.busy, e_busy);
         if (e_bus_valid) begin
            check("bus_addr", bif.bus_addr, e_addr);
            check("bus_we", bif.bus_we, e_we);
            check("bus_wdata", bif.bus_wdata, e_wdata);
            check("bus_be", bif.bus_be, e_be);
            check("bus_len", bif.bus_len, e_len);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_zero();
      @(negedge clk);
      check("rst_bus_addr", bif.bus_addr, 0);
      check("rst_bus_wdata", bif.bus_wdata, 0);
      check("rst_bus_be", bif.bus_be, 0);
      check("rst_bus_len", bif.bus_len, 0);
      check("rst_bus_we", bif.bus_we, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic mon_clear();
      mon_bus_valid = 0; mon_busy = 0; mon_last = 0; mon_rbeats = 0; mon_grant = -1;
      for (int i = 0; i < NUM_REQ; i++) mon_resp[i] = 0;
   endtask

   task automatic set_idle_exp();
      e_req_ready = '0; e_resp_valid = '0; e_resp_data = '0;
      e_resp_last = 1'b0; e_bus_valid = 1'b0; e_busy = 1'b0;
   endtask

   task automatic pack();
      bif.req_addr  = {a_addr[2], a_addr[1], a_addr[0]};
      bif.req_wdata = {a_wdata[2], a_wdata[1], a_wdata[0]};
      bif.req_be    = {a_be[2], a_be[1], a_be[0]};
      bif.req_len   = {a_len[2], a_len[1], a_len[0]};
      bif.req_we    = {a_we[2], a_we[1], a_we[0]};
   endtask

   task automatic rand_reqs();
      for (int i = 0; i < NUM_REQ; i++) begin
         a_addr[i]  = $urandom;
         a_wdata[i] = $urandom;
         a_be[i]    = 4'($urandom);
         a_len[i]   = 3'($urandom);
         a_we[i]    = 1'($urandom);
      end
      pack();
   endtask

   task automatic idle_tick();
      bif.req_valid = '0; bif.bus_rvalid = 1'b0; flush = 1'b0;
      set_idle_exp();
      tick();
   endtask

   // One transaction: arbitration cycle, address phase with rdelay wait cycles, data beats.
   // flush_beat: 0 = flush in first address cycle, k = flush on beat k, -1 = none.
   // rst_beat: k = reset asserted on beat k, -1 = none.
   task automatic do_txn(input logic [2:0] valid, input int rdelay, input int flush_beat,
                         input int rst_beat, input bit gaps);
      int          w, beats, b;
      bit          dropped, d, masked;
      logic [31:0] rd;
`ifdef BUS_ARB_RR_EN
      w = pick(valid, model_start);
`else
      w = pick(valid, 0);
`endif
      masked = ((FLUSH_MASK >> w) & 3'b001) != 3'b000;
      bif.req_valid  = valid;
      bif.bus_rvalid = 1'b0;
      bif.bus_rdata  = $urandom;
      bif.bus_ready  = 1'($urandom);
      flush          = 1'($urandom);
      set_idle_exp();
      e_req_ready = 3'(1 << w);
      e_addr  = a_addr[w];
      e_we    = a_we[w];
      e_wdata = a_wdata[w];
      e_be    = a_be[w];
      e_len   = a_we[w] ? 3'd0 : a_len[w];
      tick();
      model_start   = (w + 1) % NUM_REQ;
      bif.req_valid = '0;
      dropped       = 1'b0;
      e_req_ready = '0; e_bus_valid = 1'b1; e_busy = 1'b1;
      for (int c = 0; c <= rdelay; c++) begin
         bif.bus_ready = (c == rdelay);
         flush = (flush_beat == 0 && c == 0);
         tick();
         if (flush && masked) dropped = 1'b1;
      end
      e_bus_valid   = 1'b0;
      flush         = 1'b0;
      bif.bus_ready = 1'($urandom);
      beats = int'(e_len) + 1;
      b = 1;
      while (b <= beats) begin
         rd = $urandom;
         bif.bus_rdata = rd;
         e_resp_data   = rd;
         if (gaps && $urandom_range(0, 3) == 0) begin
            bif.bus_rvalid = 1'b0;
            flush = 1'b0;
            e_resp_valid = '0; e_resp_last = 1'b0;
            tick();
         end else begin
            bif.bus_rvalid = 1'b1;
            flush = (b == flush_beat);
            rst   = (b == rst_beat);
            d = dropped | (flush & masked);
            e_resp_valid = d ? 3'b000 : 3'(1 << w);
            e_resp_last  = !d && (b == beats);
            tick();
            dropped = d;
            if (rst) begin
               rst = 1'b0;
               model_start = 0;
               bif.bus_rvalid = 1'b0; flush = 1'b0;
               set_idle_exp();
               tick_zero();
               return;
            end
            b++;
         end
      end
      bif.bus_rvalid = 1'b0;
      flush = 1'b0;
      set_idle_exp();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0;
      bif.req_valid = '0; bif.bus_ready = 1'b0; bif.bus_rvalid = 1'b0; bif.bus_rdata = '0;
      rand_reqs();
      set_idle_exp();
      mon_clear();
      tick();
      tick();
      // reset held with all requests pending: nothing may be granted
      chk_en = 1'b1;
      bif.req_valid = 3'b111;
      tick_zero();
      rst = 1'b0;
      bif.req_valid = '0;
      tick();

      // arbitration order with everybody requesting, single-beat reads
      for (int i = 0; i < NUM_REQ; i++) begin a_we[i] = 1'b0; a_len[i] = 3'd0; end
      pack();
      mon_clear(); do_txn(3'b111, 0, -1, -1, 0); check("grant_1st", mon_grant, 0);
      mon_clear(); do_txn(3'b111, 0, -1, -1, 0);
`ifdef BUS_ARB_RR_EN
      check("grant_2nd", mon_grant, 1);
`else
      check("grant_2nd", mon_grant, 0);
`endif
      mon_clear(); do_txn(3'b111, 0, -1, -1, 0);
`ifdef BUS_ARB_RR_EN
      check("grant_3rd", mon_grant, 2);
`else
      check("grant_3rd", mon_grant, 0);
`endif
      mon_clear(); do_txn(3'b110, 0, -1, -1, 0); check("grant_no0", mon_grant, 1);
      mon_clear(); do_txn(3'b100, 0, -1, -1, 0); check("grant_only2", mon_grant, 2);

      // ICache 8-beat refill with bus_ready delayed 3 cycles
      a_we[2] = 1'b0; a_len[2] = 3'd7; a_addr[2] = 32'h8000_0020; pack();
      mon_clear(); do_txn(3'b100, 3, -1, -1, 0);
      idle_tick();
      check("ic_addr_cycles", mon_bus_valid, 4);
      check("ic_beats", mon_resp[2], 8);
      check("ic_last_count", mon_last, 1);
      check("ic_busy_cycles", mon_busy, 12);

      // LSU write: len forced to 0, single ack beat
      a_we[0] = 1'b1; a_len[0] = 3'd5; a_be[0] = 4'b0011; a_wdata[0] = 32'hDEAD_BEEF; pack();
      mon_clear(); do_txn(3'b001, 0, -1, -1, 0);
      check("wr_bus_len", mon_bus_len, 0);
      check("wr_bus_be", mon_bus_be, 4'b0011);
      check("wr_ack", mon_resp[0], 1);
      check("wr_last", mon_last, 1);

      // flush on beat 3 of an ICache burst, then a normal request
      a_we[2] = 1'b0; a_len[2] = 3'd7; pack();
      mon_clear(); do_txn(3'b100, 0, 3, -1, 0);
      check("fl_ic_beats", mon_resp[2], 2);
      check("fl_bus_beats", mon_rbeats, 8);
      check("fl_ic_last", mon_last, 0);
      a_len[2] = 3'd0; pack();
      mon_clear(); do_txn(3'b100, 0, -1, -1, 0);
      check("fl_next_beats", mon_resp[2], 1);
      a_we[0] = 1'b0; a_len[0] = 3'd7; pack();
      mon_clear(); do_txn(3'b001, 0, 3, -1, 0);
      check("fl_lsu_beats", mon_resp[0], 8);
      check("fl_lsu_last", mon_last, 1);

      // reset on beat 2 of 8, then a fresh request
      a_len[2] = 3'd7; pack();
      mon_clear(); do_txn(3'b100, 0, -1, 2, 0);
      check("rst_beats", mon_resp[2], 2);
      a_we[1] = 1'b0; a_len[1] = 3'd1; pack();
      mon_clear(); do_txn(3'b010, 1, -1, -1, 0);
      check("post_rst_beats", mon_resp[1], 2);
      check("post_rst_last", mon_last, 1);

      // stray response beat while idle
      set_idle_exp();
      bif.req_valid = '0; bif.bus_rvalid = 1'b1; bif.bus_rdata = $urandom;
      @(negedge clk);
      check("stray_flag", dut.proto_err, 1);
      @(posedge clk);
      #1;
      bif.bus_rvalid = 1'b0;
      idle_tick();

      // randomized traffic
      for (int t = 0; t < 80; t++) begin
         int fb, rb;
         rand_reqs();
         fb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1;
         rb = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, 8)) : -1;
         do_txn(3'($urandom_range(1, 7)), int'($urandom_range(0, 3)), fb, rb, 1);
         if ($urandom_range(0, 2) == 0) idle_tick();
      end
      idle_tick();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
